// File: rtl/commit_unit_if.sv
// commit_unit_if: ROB head, register-file writeback, store port, flush and perf signals of the commit unit
interface commit_unit_if #(
    parameter int ROB_ID_W = 3
);
    logic                commit_valid;
    logic [ROB_ID_W-1:0] commit_id;
    logic [4:0]          commit_op;
    logic [4:0]          commit_rd;
    logic [31:0]         commit_value;
    logic [31:0]         commit_pc;
    logic [31:0]         commit_addr;
    logic                commit_pred;
    logic                commit_outcome;
    logic [31:0]         commit_pred_target;
    logic                commit_ack;
    logic                rf_we;
    logic [4:0]          rf_waddr;
    logic [31:0]         rf_wdata;
    logic [ROB_ID_W-1:0] rf_wtag;
    logic                mem_req;
    logic [31:0]         mem_addr;
    logic [31:0]         mem_wdata;
    logic [3:0]          mem_wmask;
    logic                mem_done;
    logic                flush;
    logic [31:0]         redirect_pc;
    logic [31:0]         perf_commit;
    logic [31:0]         perf_mispred;

    modport master (
        output commit_valid, commit_id, commit_op, commit_rd, commit_value, commit_pc,
               commit_addr, commit_pred, commit_outcome, commit_pred_target, mem_done,
        input  commit_ack, rf_we, rf_waddr, rf_wdata, rf_wtag, mem_req, mem_addr,
               mem_wdata, mem_wmask, flush, redirect_pc, perf_commit, perf_mispred
    );

    modport slave (
        input  commit_valid, commit_id, commit_op, commit_rd, commit_value, commit_pc,
               commit_addr, commit_pred, commit_outcome, commit_pred_target, mem_done,
        output commit_ack, rf_we, rf_waddr, rf_wdata, rf_wtag, mem_req, mem_addr,
               mem_wdata, mem_wmask, flush, redirect_pc, perf_commit, perf_mispred
    );
endinterface

// File: rtl/commit_unit.sv
// commit_unit: in-order retirement with store handshake, mispredict flush and register writeback.
// Define COMMIT_PERF_CNT_EN to build the retired-instruction and mispredict counters.
module commit_unit #(
    parameter int ROB_ID_W = 3
) (
    input logic          clk,
    input logic          rst,
    commit_unit_if.slave cu
);
    localparam logic [4:0] ALU_OP_JAL  = 5'd12;
    localparam logic [4:0] ALU_OP_JALR = 5'd13;
    localparam logic [4:0] ALU_OP_BEQ  = 5'd14;
    localparam logic [4:0] ALU_OP_BGEU = 5'd19;
    localparam logic [4:0] ALU_OP_SB   = 5'd21;
    localparam logic [4:0] ALU_OP_SH   = 5'd22;
    localparam logic [4:0] ALU_OP_SW   = 5'd23;

    typedef enum logic [1:0] {IDLE, STORE, FLUSH} state_t;

    state_t              state, state_nx;
    logic                is_store, is_branch, is_jalr, is_jal;
    logic                mispred, ack, go_flush, rf_wr, st_start;
    logic [1:0]          lane;
    logic [3:0]          st_mask;
    logic [31:0]         st_data, target;
    logic [ROB_ID_W-1:0] tag;

    assign is_store  = cu.commit_op == ALU_OP_SB || cu.commit_op == ALU_OP_SH || cu.commit_op == ALU_OP_SW;
    assign is_branch = cu.commit_op >= ALU_OP_BEQ && cu.commit_op <= ALU_OP_BGEU;
    assign is_jalr   = cu.commit_op == ALU_OP_JALR;
    assign is_jal    = cu.commit_op == ALU_OP_JAL;
    assign tag       = cu.commit_id;

    // A taken-predicted branch that was taken still mispredicts if it went somewhere else
    assign mispred = is_branch ? (cu.commit_pred != cu.commit_outcome) ||
                                 (cu.commit_pred && cu.commit_pred_target != cu.commit_addr)
                   : is_jalr && !is_jal && cu.commit_pred_target != cu.commit_addr;
    assign target  = (is_jalr || cu.commit_outcome) ? cu.commit_addr : cu.commit_pc + 32'd4;

    assign lane    = cu.commit_addr[1:0];
    assign st_mask = cu.commit_op == ALU_OP_SB ? 4'b0001 << lane
                   : cu.commit_op == ALU_OP_SH ? (lane[1] ? 4'b1100 : 4'b0011)
                   : 4'b1111;
    assign st_data = cu.commit_op == ALU_OP_SB ? {24'b0, cu.commit_value[7:0]} << {lane, 3'b000}
                   : cu.commit_op == ALU_OP_SH ? {16'b0, cu.commit_value[15:0]} << {lane[1], 4'b0000}
                   : cu.commit_value;

    always_comb begin
        state_nx = state;
        ack      = 1'b0;
        case (state)
            IDLE: begin
                ack      = rst && cu.commit_valid && !is_store;
                state_nx = cu.commit_valid && is_store ? STORE : ack && mispred ? FLUSH : IDLE;
            end
            STORE: begin
                ack      = rst && cu.commit_valid && cu.mem_done;
                state_nx = ack ? IDLE : STORE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign go_flush      = state == IDLE && ack && mispred;
    assign st_start      = state == IDLE && cu.commit_valid && is_store;
    assign rf_wr         = ack && cu.commit_rd != 5'd0 && !is_store && !is_branch;
    assign cu.commit_ack = ack;
    assign cu.flush      = state == FLUSH;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            cu.rf_we       <= 1'b0;
            cu.rf_waddr    <= '0;
            cu.rf_wdata    <= '0;
            cu.rf_wtag     <= '0;
            cu.mem_req     <= 1'b0;
            cu.mem_addr    <= '0;
            cu.mem_wdata   <= '0;
            cu.mem_wmask   <= '0;
            cu.redirect_pc <= '0;
        end else begin
            state    <= state_nx;
            cu.rf_we <= rf_wr;
            if (rf_wr) begin
                cu.rf_waddr <= cu.commit_rd;
                cu.rf_wdata <= cu.commit_value;
                cu.rf_wtag  <= tag;
            end
            if (st_start) begin
                cu.mem_req   <= 1'b1;
                cu.mem_addr  <= {cu.commit_addr[31:2], 2'b00};
                cu.mem_wdata <= st_data;
                cu.mem_wmask <= st_mask;
            end else if (state == STORE && ack) begin
                cu.mem_req <= 1'b0;
            end
            if (go_flush)
                cu.redirect_pc <= target;
        end
    end

`ifdef COMMIT_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cu.perf_commit  <= '0;
            cu.perf_mispred <= '0;
        end else begin
            cu.perf_commit  <= cu.perf_commit + {31'b0, ack};
            cu.perf_mispred <= cu.perf_mispred + {31'b0, go_flush};
        end
    end
`else
    assign cu.perf_commit  = '0;
    assign cu.perf_mispred = '0;
`endif
endmodule

// File: tb/tb_commit_unit.sv
// tb_commit_unit: randomized retirement stream checked by a queue scoreboard against a spec-level model
module tb_commit_unit;
    localparam int W = 3;
    localparam logic [4:0] ADD = 5'd0, JAL = 5'd12, JALR = 5'd13, BEQ = 5'd14, BNE = 5'd15, BGEU = 5'd19;
    localparam logic [4:0] SB = 5'd21, SH = 5'd22, SW = 5'd23;
`ifdef COMMIT_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        logic [4:0]   op;
        logic [4:0]   rd;
        logic [W-1:0] id;
        logic [31:0]  value;
        logic [31:0]  pc;
        logic [31:0]  addr;
        logic [31:0]  pt;
        logic         pred;
        logic         outcome;
    } instr_t;
    typedef struct {
        logic [4:0]   waddr;
        logic [31:0]  wdata;
        logic [W-1:0] wtag;
    } rf_exp_t;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } mem_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    commit_unit_if #(.ROB_ID_W(W)) cu ();
    commit_unit #(.ROB_ID_W(W)) dut (.clk(clk), .rst(rst), .cu(cu));

    int          checks = 0, failures = 0;
    logic [31:0] n_commit = 0, n_mispred = 0;
    rf_exp_t     rf_q[$];
    mem_exp_t    mem_q[$];
    logic [31:0] flush_q[$];
    rf_exp_t     rf_got;
    mem_exp_t    mem_cur;
    logic        mem_prev = 1'b0, flush_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_store(input logic [4:0] op);
        return op == SB || op == SH || op == SW;
    endfunction

    function automatic bit is_branch(input logic [4:0] op);
        return op >= BEQ && op <= BGEU;
    endfunction

    function automatic bit mispredicts(input instr_t i);
        if (is_branch(i.op)) return i.pred != i.outcome || (i.pred && i.outcome && i.pt != i.addr);
        if (i.op == JALR) return i.pt != i.addr;
        return 1'b0;
    endfunction

    // Store image built byte by byte: which lanes are covered and which source byte lands in each
    function automatic mem_exp_t store_image(input instr_t i);
        mem_exp_t e;
        int n, first;
        n     = i.op == SB ? 1 : i.op == SH ? 2 : 4;
        first = i.op == SB ? int'(i.addr[1:0]) : i.op == SH ? int'(i.addr[1]) * 2 : 0;
        e.addr = i.addr & 32'hFFFF_FFFC;
        e.data = 32'd0;
        e.mask = 4'd0;
        for (int k = 0; k < n; k++) begin
            e.mask[first + k]          = 1'b1;
            e.data[(first + k) * 8 +: 8] = i.value[k * 8 +: 8];
        end
        return e;
    endfunction

    function automatic instr_t mk(input logic [4:0] op, input logic [4:0] rd, input logic [W-1:0] id,
                                  input logic [31:0] value, input logic [31:0] pc, input logic [31:0] addr,
                                  input logic [31:0] pt, input logic pred, input logic outcome);
        instr_t i;
        i.op = op; i.rd = rd; i.id = id; i.value = value; i.pc = pc;
        i.addr = addr; i.pt = pt; i.pred = pred; i.outcome = outcome;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i.op      = 5'($urandom_range(0, 23));
        i.rd      = $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom_range(1, 31));
        i.id      = W'($urandom);
        i.value   = $urandom;
        i.pc      = $urandom & 32'hFFFF_FFFC;
        i.addr    = $urandom;
        i.pt      = $urandom_range(0, 1) != 0 ? i.addr : $urandom;
        i.pred    = 1'($urandom_range(0, 1));
        i.outcome = 1'($urandom_range(0, 1));
        return i;
    endfunction

    task automatic drive(input instr_t i);
        cu.commit_valid       = 1'b1;
        cu.commit_id          = i.id;
        cu.commit_op          = i.op;
        cu.commit_rd          = i.rd;
        cu.commit_value       = i.value;
        cu.commit_pc          = i.pc;
        cu.commit_addr        = i.addr;
        cu.commit_pred        = i.pred;
        cu.commit_outcome     = i.outcome;
        cu.commit_pred_target = i.pt;
    endtask

    // Entered and left just after a rising edge; expectations are queued before the head is shown
    task automatic issue(input instr_t i, input int done_delay);
        bit mp;
        rf_exp_t r;
        mp = mispredicts(i);
        if (is_store(i.op)) begin
            mem_q.push_back(store_image(i));
        end else begin
            if (i.rd != 5'd0 && !is_branch(i.op)) begin
                r.waddr = i.rd; r.wdata = i.value; r.wtag = i.id;
                rf_q.push_back(r);
            end
            if (mp) flush_q.push_back((i.op == JALR || i.outcome) ? i.addr : i.pc + 32'd4);
        end
        drive(i);
        if (is_store(i.op)) begin
            cu.mem_done = 1'b0;
            @(negedge clk);
            check("store_no_early_ack", 32'(cu.commit_ack), 32'd0);
            @(posedge clk); #1;
            repeat (done_delay) begin
                @(negedge clk);
                check("store_wait_no_ack", 32'(cu.commit_ack), 32'd0);
                @(posedge clk); #1;
            end
            cu.mem_done = 1'b1;
            @(negedge clk);
            check("store_ack_on_done", 32'(cu.commit_ack), 32'd1);
            @(posedge clk); #1;
            cu.mem_done = 1'b0;
        end else begin
            cu.mem_done = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("ack_same_cycle", 32'(cu.commit_ack), 32'd1);
            @(posedge clk); #1;
            cu.mem_done = 1'b0;
        end
        n_commit++;
        if (mp) begin
            n_mispred++;
            @(negedge clk);
            check("no_ack_in_flush", 32'(cu.commit_ack), 32'd0);
            @(posedge clk); #1;
        end
        cu.commit_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        cu.commit_valid = 1'b0;
        repeat (n) begin
            cu.mem_done = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("idle_no_ack", 32'(cu.commit_ack), 32'd0);
            @(posedge clk); #1;
        end
        cu.mem_done = 1'b0;
    endtask

    always @(negedge clk) begin
        if (cu.rf_we) begin
            check("rf_pending", 32'(rf_q.size() != 0), 32'd1);
            if (rf_q.size() != 0) begin
                rf_got = rf_q.pop_front();
                check("rf_waddr", 32'(cu.rf_waddr), 32'(rf_got.waddr));
                check("rf_wdata", cu.rf_wdata, rf_got.wdata);
                check("rf_wtag", 32'(cu.rf_wtag), 32'(rf_got.wtag));
            end
        end
        if (cu.mem_req && !mem_prev) begin
            check("mem_pending", 32'(mem_q.size() != 0), 32'd1);
            if (mem_q.size() != 0) mem_cur = mem_q.pop_front();
            check("mem_addr", cu.mem_addr, mem_cur.addr);
            check("mem_wdata", cu.mem_wdata, mem_cur.data);
            check("mem_wmask", 32'(cu.mem_wmask), 32'(mem_cur.mask));
        end else if (cu.mem_req) begin
            check("mem_addr_hold", cu.mem_addr, mem_cur.addr);
            check("mem_wdata_hold", cu.mem_wdata, mem_cur.data);
        end
        mem_prev = cu.mem_req;
        if (cu.flush) begin
            check("flush_one_cycle", 32'(flush_prev), 32'd0);
            check("flush_pending", 32'(flush_q.size() != 0), 32'd1);
            if (flush_q.size() != 0) check("redirect_pc", cu.redirect_pc, flush_q.pop_front());
        end
        flush_prev = cu.flush;
    end

    initial begin
        instr_t st;
        cu.commit_valid = 1'b0; cu.commit_id = '0; cu.commit_op = '0; cu.commit_rd = '0;
        cu.commit_value = '0; cu.commit_pc = '0; cu.commit_addr = '0; cu.commit_pred = 1'b0;
        cu.commit_outcome = 1'b0; cu.commit_pred_target = '0; cu.mem_done = 1'b0;
        repeat (2) @(posedge clk);
        cu.commit_valid = 1'b1;
        @(negedge clk);
        check("rst_ack", 32'(cu.commit_ack), 32'd0);
        check("rst_rf_we", 32'(cu.rf_we), 32'd0);
        check("rst_rf_wdata", cu.rf_wdata, 32'd0);
        check("rst_mem_req", 32'(cu.mem_req), 32'd0);
        check("rst_mem_addr", cu.mem_addr, 32'd0);
        check("rst_flush", 32'(cu.flush), 32'd0);
        check("rst_redirect", cu.redirect_pc, 32'd0);
        check("rst_perf_commit", cu.perf_commit, 32'd0);
        check("rst_perf_mispred", cu.perf_mispred, 32'd0);
        cu.commit_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;

        issue(mk(ADD, 5'd5, 3'd2, 32'h1234, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0), 0);
        idle(2);
        issue(mk(SB, 5'd0, 3'd1, 32'hAB, 32'h14, 32'h1003, 32'h0, 1'b0, 1'b0), 3);
        idle(1);
        issue(mk(BEQ, 5'd0, 3'd3, 32'h0, 32'h40, 32'h100, 32'h100, 1'b1, 1'b0), 0);
        idle(1);
        check("perf_mispred_after_beq", cu.perf_mispred, PERF ? n_mispred : 32'd0);
        issue(mk(BNE, 5'd0, 3'd4, 32'h0, 32'h60, 32'h90, 32'h80, 1'b1, 1'b1), 0);
        issue(mk(BNE, 5'd0, 3'd5, 32'h0, 32'h64, 32'h90, 32'h90, 1'b1, 1'b1), 0);
        issue(mk(ADD, 5'd0, 3'd6, 32'hDEAD, 32'h68, 32'h0, 32'h0, 1'b0, 1'b0), 0);
        issue(mk(JALR, 5'd1, 3'd7, 32'h6C, 32'h68, 32'h200, 32'h204, 1'b1, 1'b1), 0);
        issue(mk(JAL, 5'd1, 3'd0, 32'h300, 32'h200, 32'h400, 32'h0, 1'b0, 1'b0), 0);
        issue(mk(SH, 5'd0, 3'd1, 32'h5566_7788, 32'h400, 32'h2002, 32'h0, 1'b0, 1'b0), 1);
        issue(mk(SW, 5'd0, 3'd2, 32'hCAFE_F00D, 32'h404, 32'h3001, 32'h0, 1'b0, 1'b0), 0);
        idle(2);
        check("perf_commit_directed", cu.perf_commit, PERF ? n_commit : 32'd0);

        for (int n = 0; n < 250; n++) begin
            issue(rand_instr(), $urandom_range(0, 3));
            idle($urandom_range(0, 2));
        end
        idle(2);
        check("perf_commit_random", cu.perf_commit, PERF ? n_commit : 32'd0);
        check("perf_mispred_random", cu.perf_mispred, PERF ? n_mispred : 32'd0);

        st = mk(SW, 5'd0, 3'd3, 32'h0BAD_BEEF, 32'h800, 32'h4008, 32'h0, 1'b0, 1'b0);
        mem_q.push_back(store_image(st));
        drive(st);
        cu.mem_done = 1'b0;
        @(negedge clk);
        check("rst_store_no_ack", 32'(cu.commit_ack), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_store_mem_req", 32'(cu.mem_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("midstore_rst_mem_req", 32'(cu.mem_req), 32'd0);
        check("midstore_rst_ack", 32'(cu.commit_ack), 32'd0);
        check("midstore_rst_perf_commit", cu.perf_commit, 32'd0);
        check("midstore_rst_perf_mispred", cu.perf_mispred, 32'd0);
        check("midstore_rst_redirect", cu.redirect_pc, 32'd0);
        n_commit  = 0;
        n_mispred = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        issue(st, 1);
        for (int n = 0; n < 20; n++) issue(rand_instr(), $urandom_range(0, 2));
        idle(3);
        check("perf_commit_final", cu.perf_commit, PERF ? n_commit : 32'd0);
        check("perf_mispred_final", cu.perf_mispred, PERF ? n_mispred : 32'd0);
        check("rf_q_drained", 32'(rf_q.size()), 32'd0);
        check("mem_q_drained", 32'(mem_q.size()), 32'd0);
        check("flush_q_drained", 32'(flush_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
